// File: rtl/img_bit_rx.sv
// img_bit_rx: deserialises a 784-bit (28x28) image bitstream into 28-bit rows.
// Each completed row is queued in a 4-entry FIFO and offered on a valid/ready port.
// Optional feature macro: IMG_BIT_RX_POPCOUNT_EN adds row_ones, the 1-bit count of the head row.
module img_bit_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    input  logic        restart,
    output logic [27:0] row_data,
    output logic [4:0]  row_idx,
    output logic        row_valid,
    input  logic        row_ready,
    output logic        frame_done,
    output logic        overflow
`ifdef IMG_BIT_RX_POPCOUNT_EN
    ,
    output logic [4:0]  row_ones
`endif
);

    localparam int unsigned ROW_W  = 28;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned FILL_W = 3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(27);

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ROW_W-1:0]  shift_q;
    logic [CNT_W-1:0]  col_q;
    logic [CNT_W-1:0]  row_q;

    logic              sample_c;
    logic              row_end_c;
    logic              frame_end_c;
    logic [ROW_W-1:0]  row_new_c;

    logic [ROW_W-1:0]  mem_data [DEPTH];
    logic [CNT_W-1:0]  mem_idx  [DEPTH];
    logic [PTR_W-1:0]  rd_q;
    logic [PTR_W-1:0]  wr_q;
    logic [FILL_W-1:0] fill_q;

    logic              pop_c;
    logic              push_c;
    logic              drop_c;
    logic [PTR_W-1:0]  rd_d;
    logic [PTR_W-1:0]  wr_d;
    logic [FILL_W-1:0] fill_d;
    logic              head_hit_c;
    logic [ROW_W-1:0]  head_data_d;
    logic [CNT_W-1:0]  head_idx_d;

`ifdef IMG_BIT_RX_POPCOUNT_EN
    logic [CNT_W-1:0]  mem_ones [DEPTH];
    logic [CNT_W-1:0]  ones_new_c;
    logic [CNT_W-1:0]  head_ones_d;

    function automatic logic [CNT_W-1:0] ones_of(input logic [ROW_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < ROW_W; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign ones_new_c = ones_of(row_new_c);
`endif

    // Bit sampling qualifiers; restart suppresses sampling on its own edge
    assign sample_c    = (state_q == ST_RECV) && !restart;
    assign row_end_c   = sample_c && (col_q == LAST);
    assign frame_end_c = row_end_c && (row_q == LAST);
    assign row_new_c   = {shift_q[ROW_W-2:0], data_in};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RECV;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: restart always returns to RECV, last frame bit moves to DONE
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_RECV;
        end else if (frame_end_c) begin
            state_d = ST_DONE;
        end
    end

    // Shift register and column/row counters
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else if (restart) begin
            shift_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else if (sample_c) begin
            shift_q <= row_new_c;
            if (col_q == LAST) begin
                col_q <= '0;
                row_q <= (row_q == LAST) ? '0 : row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

    // FIFO control: a full FIFO still accepts a row if the head pops on the same edge
    always_comb begin
        pop_c       = row_valid && row_ready;
        push_c      = row_end_c && ((fill_q < FILL_W'(DEPTH)) || pop_c);
        drop_c      = row_end_c && !push_c;
        rd_d        = rd_q + PTR_W'(pop_c);
        wr_d        = wr_q + PTR_W'(push_c);
        fill_d      = fill_q + FILL_W'(push_c) - FILL_W'(pop_c);
        head_hit_c  = push_c && (wr_q == rd_d);
        head_data_d = head_hit_c ? row_new_c : mem_data[rd_d];
        head_idx_d  = head_hit_c ? row_q     : mem_idx[rd_d];
`ifdef IMG_BIT_RX_POPCOUNT_EN
        head_ones_d = head_hit_c ? ones_new_c : mem_ones[rd_d];
`endif
    end

    // FIFO storage, pointers and registered head/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_idx[i]  <= '0;
`ifdef IMG_BIT_RX_POPCOUNT_EN
                mem_ones[i] <= '0;
`endif
            end
            rd_q       <= '0;
            wr_q       <= '0;
            fill_q     <= '0;
            row_valid  <= 1'b0;
            row_data   <= '0;
            row_idx    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
`ifdef IMG_BIT_RX_POPCOUNT_EN
            row_ones   <= '0;
`endif
        end else begin
            if (push_c) begin
                mem_data[wr_q] <= row_new_c;
                mem_idx[wr_q]  <= row_q;
`ifdef IMG_BIT_RX_POPCOUNT_EN
                mem_ones[wr_q] <= ones_new_c;
`endif
            end
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fill_q     <= fill_d;
            row_valid  <= (fill_d != '0);
            row_data   <= head_data_d;
            row_idx    <= head_idx_d;
            overflow   <= overflow | drop_c;
            frame_done <= frame_end_c;
`ifdef IMG_BIT_RX_POPCOUNT_EN
            row_ones   <= head_ones_d;
`endif
        end
    end

endmodule

// File: tb/tb_img_bit_rx.sv
// tb_img_bit_rx: directed bench for img_bit_rx with a queue-based frame model.
module tb_img_bit_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_in = 1'b0;
    logic        restart = 1'b0;
    logic        row_ready = 1'b0;
    logic [27:0] row_data;
    logic [4:0]  row_idx;
    logic        row_valid;
    logic        frame_done;
    logic        overflow;
`ifdef IMG_BIT_RX_POPCOUNT_EN
    logic [4:0]  row_ones;
`endif

    img_bit_rx dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .restart    (restart),
        .row_data   (row_data),
        .row_idx    (row_idx),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef IMG_BIT_RX_POPCOUNT_EN
        ,
        .row_ones   (row_ones)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] d;
        logic [4:0]  idx;
    } ent_t;

    // Model: expected FIFO contents and status
    ent_t        mq[$];
    bit          m_recv;
    int          m_bits;
    logic [27:0] m_acc;
    bit          m_ovf;
    bit          m_fd;

    // Rows actually handed over by the DUT, for literal checks
    ent_t        dut_log[$];
    int          fd_seen;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic d, input logic rs, input logic rdy, input logic r);
        bit   pop;
        bit   complete;
        ent_t e;
        complete = 0;
        e.d = '0;
        e.idx = '0;
        if (r) begin
            mq.delete();
            m_recv = 1;
            m_bits = 0;
            m_acc  = '0;
            m_ovf  = 0;
            m_fd   = 0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            m_fd = 0;
            if (rs) begin
                m_recv = 1;
                m_bits = 0;
            end else if (m_recv) begin
                m_acc = {m_acc[26:0], d};
                m_bits++;
                if (m_bits % 28 == 0) begin
                    complete = 1;
                    e.d   = m_acc;
                    e.idx = 5'((m_bits / 28) - 1);
                end
                if (m_bits == 784) begin
                    m_recv = 0;
                    m_fd   = 1;
                end
            end
            if (pop) void'(mq.pop_front());
            if (complete) begin
                if (mq.size() < 4) mq.push_back(e);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("row_valid", 32'(row_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("row_data", 32'(row_data), 32'(mq[0].d));
            chk("row_idx", 32'(row_idx), 32'(mq[0].idx));
`ifdef IMG_BIT_RX_POPCOUNT_EN
            chk("row_ones", 32'(row_ones), 32'($countones(mq[0].d)));
`endif
        end
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic d, input logic rs, input logic rdy, input logic r);
        ent_t e;
        data_in   = d;
        restart   = rs;
        row_ready = rdy;
        rst       = r;
        if (row_valid && rdy && !r) begin
            e.d = row_data;
            e.idx = row_idx;
            dut_log.push_back(e);
        end
        @(posedge clk);
        model_update(d, rs, rdy, r);
        #1;
        compare_all();
        if (frame_done) fd_seen++;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(1, 0));
    endfunction

    initial begin
        m_recv = 1; m_bits = 0; m_acc = '0; m_ovf = 0; m_fd = 0; fd_seen = 0;

        // Reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_row_data", 32'(row_data), 32'h0);
        chk("rst_row_idx", 32'(row_idx), 32'h0);
        chk("rst_row_valid", 32'(row_valid), 32'h0);

        // All-ones frame, always ready
        dut_log.delete();
        fd_seen = 0;
        for (int i = 0; i < 784; i++) begin
            step(1, 0, 1, 0);
            if (i == 782) chk("ones_fd_early", 32'(frame_done), 32'h0);
            if (i == 783) chk("ones_fd_edge", 32'(frame_done), 32'h1);
        end
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        chk("ones_rows", 32'(dut_log.size()), 32'd28);
        for (int i = 0; i < dut_log.size(); i++) begin
            chk("ones_data", 32'(dut_log[i].d), 32'h0FFFFFFF);
            chk("ones_idx", 32'(dut_log[i].idx), 32'(i));
        end
        chk("ones_fd_count", 32'(fd_seen), 32'd1);
        chk("ones_ovf", 32'(overflow), 32'h0);

        // Alternating 1,0,... frame
        step(0, 1, 1, 0);
        dut_log.delete();
        for (int i = 0; i < 784; i++) step(logic'(i % 2 == 0), 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
        chk("alt_rows", 32'(dut_log.size()), 32'd28);
        for (int i = 0; i < dut_log.size(); i++)
            chk("alt_data", 32'(dut_log[i].d), 32'h0AAAAAAA);

        // Consumer stalled for a whole frame
        step(0, 1, 0, 0);
        dut_log.delete();
        for (int i = 0; i < 784; i++) begin
            step(rbit(), 0, 0, 0);
            if (i == 138) chk("stall_ovf_before", 32'(overflow), 32'h0);
            if (i == 139) chk("stall_ovf_row4", 32'(overflow), 32'h1);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk("stall_rows", 32'(dut_log.size()), 32'd4);
        for (int i = 0; i < dut_log.size(); i++)
            chk("stall_idx", 32'(dut_log[i].idx), 32'(i));
        chk("stall_ovf_sticky", 32'(overflow), 32'h1);

        // Full FIFO, row completes on the same edge as a pop
        step(0, 0, 0, 1);
        dut_log.delete();
        for (int i = 0; i < 140; i++) step(rbit(), 0, logic'(i == 139), 0);
        chk("full_pop_ovf", 32'(overflow), 32'h0);
        chk("full_pop_head", 32'(row_idx), 32'd1);
        for (int i = 0; i < 5; i++) step(rbit(), 0, 1, 0);
        chk("full_pop_rows", 32'(dut_log.size()), 32'd5);
        for (int i = 0; i < dut_log.size(); i++)
            chk("full_pop_idx", 32'(dut_log[i].idx), 32'(i));

        // Restart after bit 100 discards partial row 3
        step(0, 0, 0, 1);
        dut_log.delete();
        fd_seen = 0;
        for (int i = 0; i < 100; i++) step(rbit(), 0, 1, 0);
        step(rbit(), 1, 1, 0);
        for (int i = 0; i < 784; i++) begin
            step(rbit(), 0, 1, 0);
            if (i == 782) chk("rs_fd_early", 32'(frame_done), 32'h0);
            if (i == 783) chk("rs_fd_edge", 32'(frame_done), 32'h1);
        end
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
        chk("rs_rows", 32'(dut_log.size()), 32'd31);
        chk("rs_last_old", 32'(dut_log[2].idx), 32'd2);
        chk("rs_first_new", 32'(dut_log[3].idx), 32'd0);
        chk("rs_fd_count", 32'(fd_seen), 32'd1);

        // Reset mid-frame with two rows buffered
        step(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) step(rbit(), 0, logic'(i < 349), 0);
        chk("mid_valid_before", 32'(row_valid), 32'h1);
        step(0, 0, 1, 1);
        chk("mid_rst_valid", 32'(row_valid), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        dut_log.delete();
        for (int i = 0; i < 30; i++) step(rbit(), 0, 1, 0);
        chk("mid_new_rows", 32'(dut_log.size()), 32'd1);
        if (dut_log.size() > 0) chk("mid_new_idx", 32'(dut_log[0].idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_bit_rx.md
IMG_BIT_RX -- requirements
Module: img_bit_rx

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (rst).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port data_in  input  1  serial pixel bit, one bit per clk, MSB (pixel 0) first.
REQ-005 SHALL have port restart  input  1  one-cycle strobe; begins a new 784-bit frame.
REQ-006 SHALL have port row_data  output  28  packed row; pixel 0 of the row in bit 27.
REQ-007 SHALL have port row_idx  output  5  row number 0..27 of row_data.
REQ-008 SHALL have port row_valid  output  1  row_data/row_idx valid.
REQ-009 SHALL have port row_ready  input  1  consumer accepts the row when row_valid and row_ready are both 1.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after bit 783 is sampled.
REQ-011 SHALL have port overflow  output  1  sticky; a completed row was dropped.

Function
REQ-012 SHALL use states RECV and DONE; reset enters RECV with bit counter 0.
REQ-013 In RECV, SHALL sample data_in on every rising edge, first sample on the first edge with rst low.
REQ-014 SHALL shift bits into a 28-bit row register with a 5-bit column counter (0..27) and a 5-bit row counter (0..27).
REQ-015 On column 27, SHALL push {row, row counter} into a 4-entry row FIFO, clear the column counter and increment the row counter.
REQ-016 On column 27 of row 27, SHALL enter DONE and pulse frame_done for exactly one cycle, on the next edge.
REQ-017 In DONE, SHALL ignore data_in; the FIFO keeps draining.
REQ-018 restart SHALL clear the column and row counters and enter RECV; the first frame bit is sampled on the edge after restart.
REQ-019 restart SHALL leave FIFO contents and overflow unchanged; if asserted during RECV, it discards the partial row.
REQ-020 row_valid SHALL be 1 exactly when the FIFO is non-empty; row_data/row_idx SHALL present the head entry.
REQ-021 Row latency SHALL be 1 cycle: row_valid rises on the edge after the row's last bit is sampled, if the FIFO was empty.
REQ-022 A pop SHALL occur when row_valid and row_ready are both 1; row_data SHALL be stable while row_valid is 1 and row_ready is 0.
REQ-023 A push SHALL succeed if the FIFO count is below 4, or if count is 4 and a pop happens in the same cycle.
REQ-024 Otherwise the push SHALL be dropped and overflow set until reset; the row counter SHALL still advance.
REQ-025 FIFO pointers SHALL be 2 bits and wrap modulo 4; the count SHALL be 3 bits.

Reset
REQ-026 On rst, SHALL force state RECV, all counters 0, FIFO empty, and row_valid, frame_done and overflow to 0.
REQ-027 Output reset values: row_data 0, row_idx 0.
REQ-028 rst mid-frame SHALL discard all partial and buffered data; rst SHALL take priority over restart.

Configuration
REQ-029 Macro IMG_BIT_RX_POPCOUNT_EN, when defined, SHALL add output row_ones (5 bits): the count of 1-bits in the head row, stored alongside it in the FIFO; reset value 0.
REQ-030 When IMG_BIT_RX_POPCOUNT_EN is undefined, row_ones and its FIFO storage SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-031 Release rst, drive 784 bits of all-ones with row_ready=1 -> 28 rows of 28'hFFFFFFF, row_idx 0..27 in order, frame_done one cycle after bit 783, overflow=0.
REQ-032 Drive an alternating pattern 1,0,1,0... -> every row_data = 28'hAAAAAAA; with IMG_BIT_RX_POPCOUNT_EN, row_ones=14.
REQ-033 Hold row_ready=0 for a full frame -> rows 0..3 buffered, overflow=1 at the end of row 4; after ready, rows 0,1,2,3 pop in order.
REQ-034 FIFO full; row completes on the same cycle as a pop -> no overflow; the new row is queued as the 4th entry.
REQ-035 Pulse restart after bit 100 -> partial row 3 is discarded; the next rows output start at row_idx 0; frame_done after 784 further bits.
REQ-036 Assert rst at bit 400 with 2 rows buffered -> next cycle row_valid=0, overflow=0; a new frame starts at row_idx 0.
